keypad_events: RTL and testbench
================================

# keypad_events

Parametrised keypad front end for the console core. Samples a raw key matrix on a slow tick (typically the vsync edge), debounces each key independently, and turns stable state changes into a buffered stream of press/release events with a valid/ready handshake. It replaces the single-register "last key plus release pulse" scheme. The CPU keeps the level view (`keys_stable`) for skip-if-pressed opcodes and pops events for wait-for-key.

## Interface
Parameters:
- `NUM_KEYS`, 16: number of keys; keys are indexed 0..NUM_KEYS-1.
- `INDEX_W`, 4: width of key indices; must satisfy 2^INDEX_W ≥ NUM_KEYS.
- `DEBOUNCE`, 3: consecutive disagreeing samples needed to flip a key's stable state; minimum 1.
- `FIFO_DEPTH`, 4: event buffer entries; power of two, minimum 2.

Ports:
- `clk`, input, 1: single clock; all state is updated on the rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `sample_en`, input, 1: one-cycle sample tick.
- `keypad_matrix`, input, NUM_KEYS: raw key levels, 1 = pressed.
- `ev_ready`, input, 1: consumer accepts the head event.
- `overflow_clr`, input, 1: clears `overflow`.
- `keys_stable`, output, NUM_KEYS: debounced key levels.
- `any_pressed`, output, 1: OR of `keys_stable`.
- `ev_valid`, output, 1: an event is at the FIFO head.
- `ev_index`, output, INDEX_W: key index of the head event.
- `ev_press`, output, 1: 1 = press event, 0 = release event.
- `last_index`, output, INDEX_W: index of the most recently queued press event.
- `overflow`, output, 1: sticky flag, an event was dropped.
- `busy`, output, 1: a scan is in progress.

## Operation
- Reset clears every output and all internal state to 0: stable levels, counters, FIFO pointers, scan state, `overflow`, `last_index`.
- States:
  - IDLE: `sample_en` moves to SCAN with scan pointer k = 0.
  - SCAN: one key per cycle, k = 0..NUM_KEYS-1; returns to IDLE after key NUM_KEYS-1.
- `sample_en` received during SCAN is ignored. Integrators must space ticks at least NUM_KEYS+1 cycles apart.
- Debounce, per key, evaluated on its scan cycle:
  - If raw equals stable, the key's counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE, stable flips, the counter clears, and an event (k, new level) is produced.
  - Counter width is $clog2(DEBOUNCE+1). DEBOUNCE = 1 means a flip on the first disagreeing sample.
- Raw input is captured for all keys in the `sample_en` cycle. Changes during the scan do not affect that scan.
- Event order within one scan is ascending key index.
- A press event updates `last_index` in the same edge it is pushed, even if the push is dropped.
- FIFO is show-ahead:
  - Pop occurs on a clock edge with `ev_valid && ev_ready`.
  - Push on full, without a simultaneous pop, drops the event and sets `overflow`.
  - Push and pop together when full: both proceed and the event is kept.
  - Push and pop together when empty: no bypass; the event is pushed.
  - `overflow_clr` clears the flag; a simultaneous overflow wins and the flag stays 1.
- `rst` mid-scan aborts the scan, discards FIFO contents and returns to IDLE.
- Pointer arithmetic wraps modulo FIFO_DEPTH, with one extra bit to distinguish full from empty.

## Timing
- `sample_en` at cycle t puts key k on scan cycle t+1+k. `busy` is high for cycles t+1..t+NUM_KEYS.
- `keys_stable[k]` updates at the edge ending cycle t+1+k.
- An event for key k, pushed into an empty FIFO, shows `ev_valid` = 1 from cycle t+2+k.
- After a pop, the next entry is presented the following cycle. `ev_valid` drops the cycle after the last pop.
- `any_pressed` is a registered OR; it lags `keys_stable` by one cycle.
- Worst case from raw change to event: DEBOUNCE sample periods plus NUM_KEYS+1 cycles.

## Configuration
- `KEYPAD_RELEASE_EVENTS_EN` defined: both press and release events are queued, as described above.
- Not defined:
  - Only press events are queued; releases still update `keys_stable` but produce no push.
  - `ev_press` is tied to 1.
  - Wait-for-key then fires on press rather than release.

## Test plan
- Reset/idle: hold `rst` for 2 cycles, then no stimulus. Required: all outputs 0, `ev_valid` stays 0, `busy` stays 0.
- Debounce (DEBOUNCE=3):
  - Key 5 raw high for 2 ticks, then low. Required: no event, `keys_stable`=0.
  - Key 5 held high for 3 ticks. Required: `keys_stable[5]`=1 after the third tick's scan; event (5, press) with `ev_valid` at t+7; `last_index`=5.
- Multi-key ordering: keys 12, 3 and 0 pressed on the same tick, with `ev_ready`=1. Required: events popped in order 0, 3, 12, all with press = 1.
- Overflow (FIFO_DEPTH=4): `ev_ready`=0 and 6 keys pressed at once. Required: the first 4 indices are retained, `overflow`=1. `overflow_clr` then clears it. Draining returns the 4 events in order.
- Full plus simultaneous pop: FIFO full, `ev_ready`=1 while a new event is pushed. Required: no drop, `overflow` stays 0.
- Release and reset:
  - With the macro, release of key 9 yields (9, 0).
  - Without the macro, no release event and `ev_press` constant 1.
  - `rst` asserted at scan cycle k=7 with 2 events queued. Required: `ev_valid`=0 and `busy`=0 the next cycle.

Source files
------------

// File: rtl/keypad_events.sv
// Keypad front end: per-key debounce on a sampled scan, press/release events into a show-ahead FIFO.
// Define KEYPAD_RELEASE_EVENTS_EN to queue release events as well as presses.
module keypad_events #(
    parameter int NUM_KEYS   = 16,
    parameter int INDEX_W    = 4,
    parameter int DEBOUNCE   = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_en,
    input  logic [NUM_KEYS-1:0] keypad_matrix,
    input  logic                ev_ready,
    input  logic                overflow_clr,
    output logic [NUM_KEYS-1:0] keys_stable,
    output logic                any_pressed,
    output logic                ev_valid,
    output logic [INDEX_W-1:0]  ev_index,
    output logic                ev_press,
    output logic [INDEX_W-1:0]  last_index,
    output logic                overflow,
    output logic                busy
);

    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [INDEX_W-1:0] KEY_LAST = INDEX_W'(NUM_KEYS - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    typedef struct packed {
        logic [INDEX_W-1:0] index;
        logic               press;
    } event_t;

    state_t              state, state_next;
    logic                start;
    logic [INDEX_W-1:0]  scan_ptr;
    logic [NUM_KEYS-1:0] raw_cap;
    logic [CNT_W-1:0]    cnt [NUM_KEYS];

    event_t              fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]      wr_ptr, rd_ptr;
    event_t              head, new_ev;

    logic cur_raw, cur_stable, flip, push, pop, full, drop;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sample_en) state_next = SCAN;
            SCAN:    if (scan_ptr == KEY_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        start = 1'b0;
        busy  = 1'b0;
        case (state)
            IDLE:    start = sample_en;
            SCAN:    busy  = 1'b1;
            default: ;
        endcase
    end

    // The key under the scan pointer is the only one whose counter/level may change this cycle.
    assign cur_raw    = raw_cap[scan_ptr];
    assign cur_stable = keys_stable[scan_ptr];
    assign flip       = busy && (cur_raw != cur_stable) && (cnt[scan_ptr] == CNT_LAST);

`ifdef KEYPAD_RELEASE_EVENTS_EN
    assign push = flip;
`else
    assign push = flip && cur_raw;
`endif

    assign new_ev   = '{index: scan_ptr, press: cur_raw};
    assign ev_valid = (wr_ptr != rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop      = ev_valid && ev_ready;
    assign drop     = push && full && !pop;
    assign head     = fifo_mem[rd_ptr[PTR_W-1:0]];
    assign ev_index = ev_valid ? head.index : '0;

`ifdef KEYPAD_RELEASE_EVENTS_EN
    assign ev_press = ev_valid && head.press;
`else
    assign ev_press = ev_valid ? head.press : 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_ptr    <= '0;
            raw_cap     <= '0;
            keys_stable <= '0;
            any_pressed <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overflow    <= 1'b0;
            last_index  <= '0;
            for (int i = 0; i < NUM_KEYS; i++) cnt[i] <= '0;
        end else begin
            any_pressed <= |keys_stable;

            if (start) begin
                raw_cap  <= keypad_matrix;
                scan_ptr <= '0;
            end else if (busy) begin
                scan_ptr <= scan_ptr + INDEX_W'(1);
            end

            if (busy) begin
                if (cur_raw == cur_stable) begin
                    cnt[scan_ptr] <= '0;
                end else if (flip) begin
                    cnt[scan_ptr]         <= '0;
                    keys_stable[scan_ptr] <= cur_raw;
                end else begin
                    cnt[scan_ptr] <= cnt[scan_ptr] + CNT_W'(1);
                end
            end

            // A press records its index even when the FIFO has no room for it.
            if (push && cur_raw) last_index <= scan_ptr;
            if (push && !drop)   wr_ptr     <= wr_ptr + (PTR_W+1)'(1);
            if (pop)             rd_ptr     <= rd_ptr + (PTR_W+1)'(1);

            if (drop)              overflow <= 1'b1;
            else if (overflow_clr) overflow <= 1'b0;
        end
    end

    // NOTE: the event storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && push && !drop) fifo_mem[wr_ptr[PTR_W-1:0]] <= new_ev;
    end

endmodule

// File: tb/tb_keypad_events.sv
// Self-checking bench for keypad_events: directed scenarios plus randomized ticks against an event-level model.
// Honours KEYPAD_RELEASE_EVENTS_EN the same way the design does.
module tb_keypad_events;

    localparam int NUM_KEYS   = 16;
    localparam int INDEX_W    = 4;
    localparam int DEBOUNCE   = 3;
    localparam int FIFO_DEPTH = 4;

`ifdef KEYPAD_RELEASE_EVENTS_EN
    localparam bit RELEASE_EN = 1'b1;
`else
    localparam bit RELEASE_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                sample_en;
    logic [NUM_KEYS-1:0] keypad_matrix;
    logic                ev_ready;
    logic                overflow_clr;
    logic [NUM_KEYS-1:0] keys_stable;
    logic                any_pressed;
    logic                ev_valid;
    logic [INDEX_W-1:0]  ev_index;
    logic                ev_press;
    logic [INDEX_W-1:0]  last_index;
    logic                overflow;
    logic                busy;

    always #5 clk = ~clk;

    keypad_events #(
        .NUM_KEYS  (NUM_KEYS),
        .INDEX_W   (INDEX_W),
        .DEBOUNCE  (DEBOUNCE),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_en    (sample_en),
        .keypad_matrix(keypad_matrix),
        .ev_ready     (ev_ready),
        .overflow_clr (overflow_clr),
        .keys_stable  (keys_stable),
        .any_pressed  (any_pressed),
        .ev_valid     (ev_valid),
        .ev_index     (ev_index),
        .ev_press     (ev_press),
        .last_index   (last_index),
        .overflow     (overflow),
        .busy         (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Event-level model: a tick decides every key's fate at once; results are revealed one key per cycle.
    typedef struct {
        int idx;
        bit press;
    } ev_t;

    ev_t                 m_q[$];
    int                  m_cnt [NUM_KEYS];
    bit                  pend_flip [NUM_KEYS];
    logic [NUM_KEYS-1:0] m_stable;
    bit                  m_any;
    bit                  m_overflow;
    int                  m_last;
    int                  scan_left;

    task automatic model_edge();
        bit                  pop, push, drop;
        ev_t                 e;
        int                  k;
        logic [NUM_KEYS-1:0] prev_stable;
        if (rst) begin
            m_stable   = '0;
            m_any      = 1'b0;
            m_overflow = 1'b0;
            m_last     = 0;
            scan_left  = 0;
            m_q.delete();
            for (int i = 0; i < NUM_KEYS; i++) begin
                m_cnt[i]     = 0;
                pend_flip[i] = 1'b0;
            end
            return;
        end
        prev_stable = m_stable;
        pop  = (m_q.size() > 0) && ev_ready;
        push = 1'b0;
        e    = '{idx: 0, press: 1'b0};
        if (scan_left > 0) begin
            k = NUM_KEYS - scan_left;
            if (pend_flip[k]) begin
                m_stable[k] = ~m_stable[k];
                if (RELEASE_EN || m_stable[k]) begin
                    push = 1'b1;
                    e    = '{idx: k, press: m_stable[k]};
                end
                if (m_stable[k]) m_last = k;
            end
            scan_left--;
        end else if (sample_en) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                pend_flip[i] = 1'b0;
                if (keypad_matrix[i] == m_stable[i]) begin
                    m_cnt[i] = 0;
                end else begin
                    m_cnt[i]++;
                    if (m_cnt[i] == DEBOUNCE) begin
                        pend_flip[i] = 1'b1;
                        m_cnt[i]     = 0;
                    end
                end
            end
            scan_left = NUM_KEYS;
        end
        m_any = |prev_stable;
        if (pop) void'(m_q.pop_front());
        drop = push && (m_q.size() >= FIFO_DEPTH);
        if (push && !drop) m_q.push_back(e);
        if (drop) m_overflow = 1'b1;
        else if (overflow_clr) m_overflow = 1'b0;
    endtask

    task automatic compare_all();
        check("busy", busy, scan_left > 0);
        check("keys_stable", keys_stable, m_stable);
        check("any_pressed", any_pressed, m_any);
        check("ev_valid", ev_valid, m_q.size() > 0);
        if (m_q.size() > 0) begin
            check("ev_index", ev_index, m_q[0].idx);
            check("ev_press", ev_press, m_q[0].press);
        end
        check("last_index", last_index, m_last);
        check("overflow", overflow, m_overflow);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic drain(input int n);
        ev_ready = 1'b1;
        repeat (n) cycle();
        ev_ready = 1'b0;
    endtask

    // One sample tick followed by its full scan; the raw inputs are scrambled during the scan.
    task automatic tick(input logic [NUM_KEYS-1:0] keys, input bit ready,
                        input int ready_at, input int rst_at, input bit noisy);
        keypad_matrix = keys;
        sample_en     = 1'b1;
        ev_ready      = ready;
        cycle();
        sample_en = 1'b0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            keypad_matrix = NUM_KEYS'($urandom);
            ev_ready      = (k == ready_at) ? 1'b1 : ready;
            rst           = (k == rst_at);
            if (noisy) begin
                ev_ready     = 1'($urandom_range(0, 1));
                sample_en    = ($urandom_range(0, 5) == 0);
                overflow_clr = ($urandom_range(0, 9) == 0);
            end
            cycle();
            if (k == rst_at) begin
                check("rst_mid_valid", ev_valid, 1'b0);
                check("rst_mid_busy", busy, 1'b0);
            end
        end
        rst          = 1'b0;
        sample_en    = 1'b0;
        overflow_clr = 1'b0;
        ev_ready     = ready;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [NUM_KEYS-1:0] cur;

        rst           = 1'b1;
        sample_en     = 1'b0;
        keypad_matrix = '0;
        ev_ready      = 1'b0;
        overflow_clr  = 1'b0;
        idle(2);
        rst = 1'b0;
        idle(20);
        check("reset_keys", keys_stable, '0);
        check("reset_any", any_pressed, 1'b0);
        check("reset_valid", ev_valid, 1'b0);
        check("reset_index", ev_index, '0);
        check("reset_press", ev_press, !RELEASE_EN);
        check("reset_last", last_index, '0);
        check("reset_overflow", overflow, 1'b0);
        check("reset_busy", busy, 1'b0);

        // Key 5 bounces for two ticks only: no flip.
        tick(16'h0020, 1'b0, -1, -1, 1'b0);
        tick(16'h0020, 1'b0, -1, -1, 1'b0);
        tick(16'h0000, 1'b0, -1, -1, 1'b0);
        check("bounce_keys", keys_stable, '0);
        check("bounce_valid", ev_valid, 1'b0);

        // Key 5 held for three ticks: press event.
        repeat (3) tick(16'h0020, 1'b0, -1, -1, 1'b0);
        check("press5_stable", keys_stable[5], 1'b1);
        check("press5_valid", ev_valid, 1'b1);
        check("press5_index", ev_index, 5);
        check("press5_press", ev_press, 1'b1);
        check("press5_last", last_index, 5);
        drain(4);

        // Keys 12, 3, 0 on the same tick, consumer always ready.
        repeat (3) tick(16'h1029, 1'b1, -1, -1, 1'b0);
        check("multi_last", last_index, 12);
        drain(4);

        // Six more presses with no consumer: four kept, two dropped.
        repeat (3) tick(16'h11FF, 1'b0, -1, -1, 1'b0);
        check("ovf_set", overflow, 1'b1);
        check("ovf_last", last_index, 8);
        check("ovf_head", ev_index, 1);
        overflow_clr = 1'b1;
        cycle();
        overflow_clr = 1'b0;
        check("ovf_clr", overflow, 1'b0);
        drain(6);
        check("ovf_drained", ev_valid, 1'b0);

        repeat (3) tick(16'h0000, 1'b1, -1, -1, 1'b0);
        drain(4);

        // Full FIFO with a pop on the same edge as the fifth push.
        repeat (2) tick(16'hEC00, 1'b0, -1, -1, 1'b0);
        tick(16'hEC00, 1'b0, 15, -1, 1'b0);
        check("fullpop_overflow", overflow, 1'b0);
        check("fullpop_head", ev_index, 11);
        check("fullpop_valid", ev_valid, 1'b1);
        drain(6);
        repeat (3) tick(16'h0000, 1'b1, -1, -1, 1'b0);
        drain(4);

        // Key 9 press then release.
        repeat (3) tick(16'h0200, 1'b1, -1, -1, 1'b0);
        drain(3);
        repeat (3) tick(16'h0000, 1'b0, -1, -1, 1'b0);
        check("release_valid", ev_valid, RELEASE_EN);
        check("release_press", ev_press, !RELEASE_EN);
        check("release_last", last_index, 9);
        check("release_keys", keys_stable, '0);
        drain(3);

        // Two events queued, then reset lands mid-scan at key 7.
        repeat (3) tick(16'h0006, 1'b0, -1, -1, 1'b0);
        check("pre_rst_valid", ev_valid, 1'b1);
        tick(16'h0006, 1'b0, -1, 7, 1'b0);
        idle(3);

        // Randomized ticks with random backpressure, clears and ignored mid-scan ticks.
        cur = '0;
        for (int n = 0; n < 150; n++) begin
            cur ^= NUM_KEYS'($urandom) & NUM_KEYS'($urandom);
            tick(cur, 1'($urandom_range(0, 1)), -1, -1, 1'b1);
            repeat ($urandom_range(0, 3)) begin
                ev_ready     = 1'($urandom_range(0, 1));
                overflow_clr = ($urandom_range(0, 7) == 0);
                cycle();
            end
            ev_ready     = 1'b0;
            overflow_clr = 1'b0;
        end
        drain(8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
